// File: rtl/park_pkg.sv
// Shared definitions for the forward Park transform: default widths, FSM
// encoding and the clamp limits for the default data width.
package park_pkg;

  localparam int D_WIDTH_DEF = 19;
  localparam int Q_BITS_DEF  = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SAT  = 2'd2
  } park_state_e;

  localparam longint SAT_MAX_DEF = (64'sd1 <<< (D_WIDTH_DEF - 1)) - 64'sd1;
  localparam longint SAT_MIN_DEF = -(64'sd1 <<< (D_WIDTH_DEF - 1));

endpackage

// File: rtl/park_sat.sv
// Combinational clamp of a wide accumulator into a D_WIDTH signed result.
module park_sat #(
  parameter int D_WIDTH = 19,
  parameter int A_WIDTH = 39
) (
  input  logic signed [A_WIDTH-1:0] acc_i,
  output logic signed [D_WIDTH-1:0] val_o,
  output logic                      ovf_o
);

  // The value fits only when every bit above the result's sign bit copies it.
  always_comb begin
    ovf_o = 1'b0;
    val_o = acc_i[D_WIDTH-1:0];
    if (acc_i[A_WIDTH-1:D_WIDTH-1] != {(A_WIDTH-D_WIDTH+1){acc_i[A_WIDTH-1]}}) begin
      ovf_o = 1'b1;
      val_o = acc_i[A_WIDTH-1] ? {1'b1, {(D_WIDTH-1){1'b0}}}
                               : {1'b0, {(D_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/forward_park.sv
// Forward Park transform D/Q from alpha/beta and sin/cos using one shared
// multiplier stepped over four product cycles, then a saturating output stage.
module forward_park
  import park_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int Q_BITS  = Q_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic signed [D_WIDTH-1:0] alpha,
  input  logic signed [D_WIDTH-1:0] beta,
  input  logic signed [D_WIDTH-1:0] sin,
  input  logic signed [D_WIDTH-1:0] cos,
  input  logic                      start,
  output logic signed [D_WIDTH-1:0] D,
  output logic signed [D_WIDTH-1:0] Q,
  output logic                      busy,
  output logic                      done,
  output logic                      sat,
  output logic [1:0]                dbg_state
);

  localparam int P_WIDTH = 2 * D_WIDTH;
  localparam int A_WIDTH = 2 * D_WIDTH + 1;

  // Handshake: start is sampled only while IDLE (busy low); the operands are
  // captured on that edge and done pulses for exactly one cycle when D/Q/sat
  // update. start while busy is dropped, nothing is queued.

  park_state_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic signed [D_WIDTH-1:0] alpha_q, alpha_d, beta_q, beta_d;
  logic signed [D_WIDTH-1:0] sin_q, sin_d, cos_q, cos_d;
  logic signed [A_WIDTH-1:0] accd_q, accd_d, accq_q, accq_d;
  logic signed [D_WIDTH-1:0] dout_q, dout_d, qout_q, qout_d;
  logic                      sat_q, sat_d, done_q, done_d;

  logic signed [D_WIDTH-1:0] mul_a, mul_b;
  logic signed [P_WIDTH-1:0] prod, prod_sh;
  logic signed [A_WIDTH-1:0] term;
  logic signed [D_WIDTH-1:0] d_clamp, q_clamp;
  logic                      d_ovf, q_ovf;

  always_comb begin
    mul_a = alpha_q;
    mul_b = cos_q;
    case (idx_q)
      2'd1:    begin mul_a = beta_q;  mul_b = sin_q; end
      2'd2:    begin mul_a = beta_q;  mul_b = cos_q; end
      2'd3:    begin mul_a = alpha_q; mul_b = sin_q; end
      default: begin mul_a = alpha_q; mul_b = cos_q; end
    endcase
  end

  assign prod    = mul_a * mul_b;
  assign prod_sh = prod >>> Q_BITS;
  assign term    = {prod_sh[P_WIDTH-1], prod_sh};

  park_sat #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_sat_d (
    .acc_i(accd_q), .val_o(d_clamp), .ovf_o(d_ovf)
  );

  park_sat #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_sat_q (
    .acc_i(accq_q), .val_o(q_clamp), .ovf_o(q_ovf)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    sin_d   = sin_q;
    cos_d   = cos_q;
    accd_d  = accd_q;
    accq_d  = accq_q;
    dout_d  = dout_q;
    qout_d  = qout_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          alpha_d = alpha;
          beta_d  = beta;
          sin_d   = sin;
          cos_d   = cos;
          accd_d  = '0;
          accq_d  = '0;
          idx_d   = 2'd0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        idx_d = idx_q + 2'd1;
        case (idx_q)
          2'd0, 2'd1: accd_d = accd_q + term;
          2'd2:       accq_d = accq_q + term;
          default: begin
            accq_d  = accq_q - term;
            state_d = ST_SAT;
          end
        endcase
      end
      ST_SAT: begin
        dout_d  = d_clamp;
        qout_d  = q_clamp;
        sat_d   = d_ovf | q_ovf;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      alpha_q <= '0;
      beta_q  <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      accd_q  <= '0;
      accq_q  <= '0;
      dout_q  <= '0;
      qout_q  <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      alpha_q <= alpha_d;
      beta_q  <= beta_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      accd_q  <= accd_d;
      accq_q  <= accq_d;
      dout_q  <= dout_d;
      qout_q  <= qout_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  assign D         = dout_q;
  assign Q         = qout_q;
  assign sat       = sat_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_forward_park.sv
// Directed bench for forward_park: a vector table of hand-computed results
// plus sequences for back-to-back start, ignored start and mid-op reset.
module tb_forward_park;

  logic clk;
  logic rstb;
  logic signed [18:0] alpha, beta, sin, cos;
  logic start;
  logic signed [18:0] D, Q;
  logic busy, done, sat;
  logic [1:0] dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string name;
    int    alpha;
    int    beta;
    int    sn;
    int    cs;
    int    exp_d;
    int    exp_q;
    int    exp_sat;
  } vec_t;

  vec_t vecs[8];

  forward_park #(.D_WIDTH(19), .Q_BITS(15)) dut (
    .clk(clk), .rstb(rstb), .alpha(alpha), .beta(beta), .sin(sin), .cos(cos),
    .start(start), .D(D), .Q(Q), .busy(busy), .done(done), .sat(sat),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int i);
    alpha = 19'(vecs[i].alpha);
    beta  = 19'(vecs[i].beta);
    sin   = 19'(vecs[i].sn);
    cos   = 19'(vecs[i].cs);
  endtask

  task automatic scramble();
    alpha = 19'($urandom_range(0, 524287));
    beta  = 19'($urandom_range(0, 524287));
    sin   = 19'($urandom_range(0, 524287));
    cos   = 19'($urandom_range(0, 524287));
  endtask

  task automatic run_op(input int i);
    int lat;
    lat = 99;
    @(negedge clk);
    drive(i);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    scramble();
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    chk({vecs[i].name, "_latency"}, lat, 5);
    chk({vecs[i].name, "_d"}, int'(D), vecs[i].exp_d);
    chk({vecs[i].name, "_q"}, int'(Q), vecs[i].exp_q);
    chk({vecs[i].name, "_sat"}, int'(sat), vecs[i].exp_sat);
    @(posedge clk);
    #1;
    chk({vecs[i].name, "_done_pulse"}, int'(done), 0);
    chk({vecs[i].name, "_d_hold"}, int'(D), vecs[i].exp_d);
  endtask

  initial begin
    int n_done;
    int done_edge;

    vecs[0] = '{"unit_cos",   4096,    0,       0,     32767,  4095,    0,      0};
    vecs[1] = '{"unit_sin",   4096,    0,       32767, 0,      0,       -4095,  0};
    vecs[2] = '{"floor_neg",  -2,      0,       0,     23173,  -2,      0,      0};
    vecs[3] = '{"sat_pos",    262143,  262143,  23170, 23170,  262143,  0,      1};
    vecs[4] = '{"sat_neg",    -262144, -262144, 23170, 23170,  -262144, 0,      1};
    vecs[5] = '{"mixed",      1000,    2000,    -16384, 16384, -500,    1500,   0};
    vecs[6] = '{"floor_mix",  -3,      5,       1,     16385,  -2,      3,      0};
    vecs[7] = '{"q_sat",      -262144, 262143,  32767, 32767,  -1,      262143, 1};

    rstb  = 1'b0;
    start = 1'b0;
    alpha = '0;
    beta  = '0;
    sin   = '0;
    cos   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d", int'(D), 0);
    chk("rst_q", int'(Q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sat", int'(sat), 0);
    @(negedge clk);
    rstb = 1'b1;

    for (int i = 0; i < 8; i++) run_op(i);

    // start held high: one result every six cycles, busy drops with done
    @(negedge clk);
    drive(0);
    start = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("held_done_e%0d", k), int'(done), (k % 6 == 5) ? 1 : 0);
      chk($sformatf("held_busy_e%0d", k), int'(busy), (k % 6 == 5) ? 0 : 1);
    end
    @(negedge clk);
    start = 1'b0;
    chk("held_d", int'(D), 4095);

    // a second start pulse at edge 2 must be ignored
    @(negedge clk);
    drive(5);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    scramble();
    @(posedge clk);
    @(negedge clk);
    drive(0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_done    = 0;
    done_edge = -1;
    for (int e = 3; e <= 14; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        done_edge = e;
      end
    end
    chk("busy_start_done_count", n_done, 1);
    chk("busy_start_done_edge", done_edge, 5);
    chk("busy_start_d", int'(D), -500);
    chk("busy_start_q", int'(Q), 1500);

    // reset at edge 3 aborts; reset also wins over a simultaneous start
    @(negedge clk);
    drive(0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstb = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_d", int'(D), 0);
    chk("abort_q", int'(Q), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_vs_start_busy", int'(busy), 0);
    @(negedge clk);
    rstb  = 1'b1;
    start = 1'b0;
    n_done = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    run_op(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
